// File: rtl/gate_chk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gate_chk_pkg                                                               |
// | Shared state encoding, function codes and reference gate function.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package gate_chk_pkg;

  localparam int MAX_N_IN = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] FN_AND  = 3'd0;
  localparam logic [2:0] FN_OR   = 3'd1;
  localparam logic [2:0] FN_NAND = 3'd2;
  localparam logic [2:0] FN_NOR  = 3'd3;
  localparam logic [2:0] FN_XOR  = 3'd4;

  // mask marks the live input bits; unused upper bits must not disturb the reduction
  function automatic logic gate_ref(input logic [2:0]          func,
                                    input logic [MAX_N_IN-1:0] vec,
                                    input logic [MAX_N_IN-1:0] mask);
    logic w_and;
    logic w_or;
    logic w_xor;
    w_and = &(vec | ~mask);
    w_or  = |(vec & mask);
    w_xor = ^(vec & mask);
    case (func)
      FN_AND:  gate_ref = w_and;
      FN_OR:   gate_ref = w_or;
      FN_NAND: gate_ref = ~w_and;
      FN_NOR:  gate_ref = ~w_or;
      FN_XOR:  gate_ref = w_xor;
      default: gate_ref = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_ref_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gate_ref_model                                                             |
// | Combinational reference output for the selected gate function.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gate_ref_model #(
  parameter int N_IN = 2,
  parameter int FUNC = 0
) (
  input  logic [N_IN-1:0] i_vec,
  output logic            o_ref
);
  import gate_chk_pkg::*;

  localparam logic [MAX_N_IN-1:0] c_MASK = MAX_N_IN'((1 << N_IN) - 1);

  logic [MAX_N_IN-1:0] w_vec;

  assign w_vec = MAX_N_IN'(i_vec);
  assign o_ref = gate_ref(3'(FUNC), w_vec, c_MASK);

endmodule
`default_nettype wire

// File: rtl/gate_vector_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gate_vector_checker                                                        |
// | Exhaustive stimulus sequencer and sampled response checker for one gate.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gate_vector_checker #(
  parameter int N_IN   = 2,
  parameter int HOLD   = 10,
  parameter int SETTLE = 2,
  parameter int FUNC   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_dut_y,
  output logic [N_IN-1:0] o_vec_out,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_count,
  output logic            o_fail_valid,
  output logic [N_IN-1:0] o_first_fail_vec
);
  import gate_chk_pkg::*;

  localparam int              c_CW      = $clog2(HOLD);
  localparam logic [c_CW-1:0] c_LAST    = c_CW'(HOLD - 1);
  localparam logic [c_CW-1:0] c_SAMPLE  = c_CW'(SETTLE);
  localparam logic [N_IN-1:0] c_VEC_MAX = '1;

  if (N_IN < 1 || N_IN > MAX_N_IN || HOLD < 2 || SETTLE < 0 || SETTLE >= HOLD ||
      FUNC < 0 || FUNC > 4) begin : g_param_check
    $error("gate_vector_checker: illegal parameter combination");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CW-1:0]   r_cnt;
  logic [N_IN-1:0]   r_vec;
  logic [N_IN:0]     r_err;
  logic              r_fail_valid;
  logic [N_IN-1:0]   r_first_fail;

  logic w_ref;
  logic w_start_ok;
  logic w_mismatch;
  logic w_win_end;
  logic w_last_vec;

  gate_ref_model #(
    .N_IN (N_IN),
    .FUNC (FUNC)
  ) u_ref (
    .i_vec (r_vec),
    .o_ref (w_ref)
  );

  // dut_y matters only on the single settle edge of each window
  assign w_start_ok = i_start && (r_state != ST_RUN);
  assign w_mismatch = (r_state == ST_RUN) && (r_cnt == c_SAMPLE) && (i_dut_y != w_ref);
  assign w_win_end  = (r_state == ST_RUN) && (r_cnt == c_LAST);
  assign w_last_vec = (r_vec == c_VEC_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_win_end && w_last_vec) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_vec        <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
    end else if (w_start_ok) begin
      r_cnt        <= '0;
      r_vec        <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
    end else if (r_state == ST_RUN) begin
      if (w_mismatch) begin
        r_err <= r_err + 1'b1;
        if (!r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_first_fail <= r_vec;
        end
      end
      if (w_win_end) begin
        r_cnt <= '0;
        r_vec <= w_last_vec ? '0 : r_vec + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_vec_out        = r_vec;
  assign o_busy           = (r_state == ST_RUN);
  assign o_done           = (r_state == ST_DONE);
  assign o_pass           = o_done && (r_err == '0);
  assign o_err_count      = r_err;
  assign o_fail_valid     = r_fail_valid;
  assign o_first_fail_vec = r_first_fail;

endmodule
`default_nettype wire

// File: tb/tb_gate_vector_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gate_vector_checker                                                     |
// | Directed bench with an abstract run model and per-cycle output compare.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_gate_vector_checker;

  localparam int N_IN   = 2;
  localparam int HOLD   = 10;
  localparam int SETTLE = 2;
  localparam int FUNC   = 0;
  localparam int NV     = 1 << N_IN;
  localparam int RUNLEN = NV * HOLD;

  localparam int M_GOOD  = 0;
  localparam int M_TIE0  = 1;
  localparam int M_TIE1  = 2;
  localparam int M_NAND  = 3;
  localparam int M_EARLY = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic dut_y;
  int   mode;
  int   early_len;

  logic [N_IN-1:0] o_vec_out;
  logic            o_busy;
  logic            o_done;
  logic            o_pass;
  logic [N_IN:0]   o_err_count;
  logic            o_fail_valid;
  logic [N_IN-1:0] o_first_fail_vec;

  int n_tot = 0;
  int n_bad = 0;

  // abstract run model: position in run, accumulated results
  bit m_seen_rst = 1'b0;
  bit m_run      = 1'b0;
  bit m_done     = 1'b0;
  int m_pos      = 0;
  int m_err      = 0;
  bit m_fv       = 1'b0;
  int m_ffv      = 0;
  logic [N_IN-1:0] exp_vec;

  gate_vector_checker #(
    .N_IN   (N_IN),
    .HOLD   (HOLD),
    .SETTLE (SETTLE),
    .FUNC   (FUNC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (start),
    .i_dut_y          (dut_y),
    .o_vec_out        (o_vec_out),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_pass           (o_pass),
    .o_err_count      (o_err_count),
    .o_fail_valid     (o_fail_valid),
    .o_first_fail_vec (o_first_fail_vec)
  );

  always #5 clk = ~clk;

  function automatic bit ref_fn(input logic [N_IN-1:0] v);
    int ones;
    ones = $countones(v);
    case (FUNC)
      0:       return ones == N_IN;
      1:       return ones > 0;
      2:       return ones != N_IN;
      3:       return ones == 0;
      default: return (ones % 2) == 1;
    endcase
  endfunction

  always_comb begin
    dut_y = ref_fn(o_vec_out);
    case (mode)
      M_TIE0:  dut_y = 1'b0;
      M_TIE1:  dut_y = 1'b1;
      M_NAND:  dut_y = !ref_fn(o_vec_out);
      M_EARLY: if (m_run && ((m_pos % HOLD) < early_len)) dut_y = !ref_fn(o_vec_out);
      default: dut_y = ref_fn(o_vec_out);
    endcase
  end

  always_comb begin
    exp_vec = m_run ? N_IN'(m_pos / HOLD) : '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_seen_rst <= 1'b1;
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_pos  <= 0;
      m_err  <= 0;
      m_fv   <= 1'b0;
      m_ffv  <= 0;
    end else if (start && !m_run) begin
      m_run  <= 1'b1;
      m_done <= 1'b0;
      m_pos  <= 0;
      m_err  <= 0;
      m_fv   <= 1'b0;
      m_ffv  <= 0;
    end else if (m_run) begin
      if ((m_pos % HOLD) == SETTLE && dut_y != ref_fn(exp_vec)) begin
        m_err <= m_err + 1;
        if (!m_fv) begin
          m_fv  <= 1'b1;
          m_ffv <= m_pos / HOLD;
        end
      end
      if (m_pos == RUNLEN - 1) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
        m_pos  <= 0;
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_seen_rst) begin
      chk("cyc_vec",  32'(o_vec_out), 32'(exp_vec));
      chk("cyc_busy", 32'(o_busy), 32'(m_run));
      chk("cyc_done", 32'(o_done), 32'(m_done));
      chk("cyc_pass", 32'(o_pass), 32'(m_done && m_err == 0));
      chk("cyc_err",  32'(o_err_count), 32'(m_err));
      chk("cyc_fv",   32'(o_fail_valid), 32'(m_fv));
      chk("cyc_ffv",  32'(o_first_fail_vec), 32'(m_ffv));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic full_run(input int m, input int el);
    mode = m;
    early_len = el;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(RUNLEN);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mode = M_GOOD;
    early_len = 0;
    rst = 1'b1;
    start = 1'b0;
    cycles(2);
    rst = 1'b0;
    chk("rst_vec",  32'(o_vec_out), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_pass", 32'(o_pass), 0);
    chk("rst_err",  32'(o_err_count), 0);
    chk("rst_fv",   32'(o_fail_valid), 0);

    // correct AND, stray start at cycle 5
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    chk("and_vec_c1",  32'(o_vec_out), 0);
    chk("and_busy_c1", 32'(o_busy), 1);
    cycles(4);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(5);
    chk("and_vec_c11", 32'(o_vec_out), 1);
    cycles(10);
    chk("and_vec_c21", 32'(o_vec_out), 2);
    cycles(10);
    chk("and_vec_c31", 32'(o_vec_out), 3);
    cycles(9);
    chk("and_done_c40", 32'(o_done), 0);
    cycles(1);
    chk("and_done_c41", 32'(o_done), 1);
    chk("and_pass_c41", 32'(o_pass), 1);
    chk("and_err_c41",  32'(o_err_count), 0);
    chk("and_fv_c41",   32'(o_fail_valid), 0);

    // restart from DONE at cycle 45 with output stuck at 1
    cycles(4);
    mode = M_TIE1;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    chk("tie1_done_clr", 32'(o_done), 0);
    chk("tie1_busy",     32'(o_busy), 1);
    cycles(RUNLEN);
    chk("tie1_done", 32'(o_done), 1);
    chk("tie1_err",  32'(o_err_count), 3);
    chk("tie1_ffv",  32'(o_first_fail_vec), 0);
    chk("tie1_pass", 32'(o_pass), 0);

    full_run(M_TIE0, 0);
    chk("tie0_err",  32'(o_err_count), 1);
    chk("tie0_fv",   32'(o_fail_valid), 1);
    chk("tie0_ffv",  32'(o_first_fail_vec), 3);
    chk("tie0_pass", 32'(o_pass), 0);

    full_run(M_NAND, 0);
    chk("nand_err", 32'(o_err_count), 4);
    chk("nand_ffv", 32'(o_first_fail_vec), 0);

    full_run(M_EARLY, 2);
    chk("settle_pass", 32'(o_pass), 1);
    full_run(M_EARLY, 3);
    chk("settle_ctl_err", 32'(o_err_count), 4);

    // reset at cycle 15 of a failing run, then a clean run
    mode = M_NAND;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(14);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("mrst_busy", 32'(o_busy), 0);
    chk("mrst_vec",  32'(o_vec_out), 0);
    chk("mrst_err",  32'(o_err_count), 0);
    chk("mrst_done", 32'(o_done), 0);
    full_run(M_GOOD, 0);
    chk("mrst_rerun_pass", 32'(o_pass), 1);

    // rst and start together from DONE
    rst = 1'b1;
    start = 1'b1;
    cycles(1);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 32'(o_busy), 0);
    chk("rst_start_done", 32'(o_done), 0);
    cycles(3);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
